// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD scan driver: ASCII digit codes and frame FSM states.
package lcd_pkg;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] ONE   = 8'h31;
    localparam logic [7:0] TWO   = 8'h32;
    localparam logic [7:0] THREE = 8'h33;
    localparam logic [7:0] FOUR  = 8'h34;
    localparam logic [7:0] FIVE  = 8'h35;
    localparam logic [7:0] SIX   = 8'h36;
    localparam logic [7:0] SEVEN = 8'h37;
    localparam logic [7:0] EIGHT = 8'h38;
    localparam logic [7:0] NINE  = 8'h39;
    localparam logic [7:0] ERROR = 8'h3A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } frame_state_e;

endpackage

// File: rtl/bcd_to_ascii.sv
// Combinational BCD digit to ASCII character; non-decimal codes map to the ERROR glyph.
module bcd_to_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (bcd_i <= 4'd9) begin
            ascii_o = ZERO + {4'h0, bcd_i};
        end else begin
            ascii_o = ERROR;
        end
    end

endmodule

// File: rtl/lcd_scan_driver.sv
// Sends one BCD time value to an LCD a digit at a time, and raises a bounded alarm
// when the running time matches the stored alarm time.
module lcd_scan_driver
    import lcd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ALARM_CYCLES = 16,
    localparam int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] key_time,
    input  logic [4*NUM_DIGITS-1:0] alarm_time,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic                    show_new_time,
    input  logic                    show_alarm,
    input  logic                    refresh,
    input  logic                    lcd_ready,
    input  logic                    alarm_ack,
    output logic [7:0]              lcd_data,
    output logic [SEL_W-1:0]        lcd_digit_sel,
    output logic                    lcd_valid,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    sound_alarm
);

    frame_state_e            state_q, state_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [4*NUM_DIGITS-1:0] src_time;
    logic [3:0]              cur_digit;

    always_comb begin
        if (show_new_time) begin
            src_time = key_time;
        end else if (show_alarm) begin
            src_time = alarm_time;
        end else begin
            src_time = current_time;
        end
    end

    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == SEL_W'(i)) begin
                cur_digit = snap_q[4*i +: 4];
            end
        end
    end

    bcd_to_ascii u_bcd_to_ascii (
        .bcd_i   (cur_digit),
        .ascii_o (lcd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Refresh is only honoured in IDLE, so a request during a frame is dropped.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        lcd_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (refresh) begin
                    snap_d  = src_time;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                lcd_valid = 1'b1;
                if (lcd_ready) begin
                    if (idx_q == SEL_W'(NUM_DIGITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lcd_digit_sel = idx_q;

    logic        match_q, match_prev_q;
    logic        sound_q, sound_d;
    logic [15:0] cnt_q, cnt_d;
    logic        match_rise;

    assign match_rise = match_q & ~match_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
            sound_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            match_q      <= (current_time == alarm_time);
            match_prev_q <= match_q;
            sound_q      <= sound_d;
            cnt_q        <= cnt_d;
        end
    end

    // Ack outranks a fresh rising match; a rising match while sounding restarts the count.
    always_comb begin
        sound_d = sound_q;
        cnt_d   = cnt_q;
        if (alarm_ack) begin
            sound_d = 1'b0;
            cnt_d   = '0;
        end else if (match_rise) begin
            sound_d = 1'b1;
            cnt_d   = '0;
        end else if (sound_q) begin
            if (cnt_q == 16'(ALARM_CYCLES - 1)) begin
                sound_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign sound_alarm = sound_q;

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Scoreboard bench for lcd_scan_driver: frames queue expected characters, a negedge monitor checks them.
module tb_lcd_scan_driver;

    logic        clock;
    logic        reset;
    logic [15:0] key_time;
    logic [15:0] alarm_time;
    logic [15:0] current_time;
    logic        show_new_time;
    logic        show_alarm;
    logic        refresh;
    logic        lcd_ready;
    logic        alarm_ack;
    logic [7:0]  lcd_data;
    logic [1:0]  lcd_digit_sel;
    logic        lcd_valid;
    logic        frame_done;
    logic        busy;
    logic        sound_alarm;

    lcd_scan_driver #(
        .NUM_DIGITS   (4),
        .ALARM_CYCLES (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_time      (key_time),
        .alarm_time    (alarm_time),
        .current_time  (current_time),
        .show_new_time (show_new_time),
        .show_alarm    (show_alarm),
        .refresh       (refresh),
        .lcd_ready     (lcd_ready),
        .alarm_ack     (alarm_ack),
        .lcd_data      (lcd_data),
        .lcd_digit_sel (lcd_digit_sel),
        .lcd_valid     (lcd_valid),
        .frame_done    (frame_done),
        .busy          (busy),
        .sound_alarm   (sound_alarm)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    logic done_exp;
    int   n_chk;
    int   n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        exp_t e;
        logic [7:0] b[4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < 4; i++) begin
            e.data = b[i];
            e.sel  = 2'(i);
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        refresh = 1'b1;
        @(posedge clock);
        #1;
        refresh = 1'b0;
        push_frame(b0, b1, b2, b3);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || done_exp) && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("frame_timeout", (cyc >= 50), 0);
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs compared against the head of the expected-character queue.
    always @(negedge clock) begin
        chk("lcd_valid", lcd_valid, (exp_q.size() != 0));
        chk("frame_done", frame_done, done_exp);
        chk("busy", busy, (exp_q.size() != 0) || done_exp);
        done_exp = 1'b0;
        if (lcd_valid && exp_q.size() != 0) begin
            chk("lcd_data", lcd_data, exp_q[0].data);
            chk("lcd_digit_sel", lcd_digit_sel, exp_q[0].sel);
            if (lcd_ready) begin
                if (exp_q[0].last) done_exp = 1'b1;
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        done_exp = 1'b0;
        reset = 1'b1;
        key_time = 16'h0000;
        alarm_time = 16'h0700;
        current_time = 16'h0000;
        show_new_time = 1'b0;
        show_alarm = 1'b0;
        refresh = 1'b0;
        lcd_ready = 1'b1;
        alarm_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_lcd_data", lcd_data, 8'h30);
        chk("rst_sel", lcd_digit_sel, 2'd0);
        chk("rst_valid", lcd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_sound", sound_alarm, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Plain frame from current_time, with a refresh issued mid-frame that must be dropped.
        current_time = 16'h1234;
        start_frame(8'h34, 8'h33, 8'h32, 8'h31);
        refresh = 1'b1;
        @(posedge clock);
        #1;
        refresh = 1'b0;
        current_time = 16'h9999;
        wait_idle();
        current_time = 16'h0000;

        // Priority to key_time plus three cycles of backpressure on digit 0.
        show_new_time = 1'b1;
        show_alarm = 1'b1;
        key_time = 16'h0009;
        lcd_ready = 1'b0;
        start_frame(8'h39, 8'h30, 8'h30, 8'h30);
        repeat (3) @(posedge clock);
        #1;
        lcd_ready = 1'b1;
        wait_idle();

        // Non-decimal digit gives the ERROR glyph.
        key_time = 16'h5B07;
        start_frame(8'h37, 8'h30, 8'h3A, 8'h35);
        wait_idle();

        // alarm_time as source.
        show_new_time = 1'b0;
        start_frame(8'h30, 8'h30, 8'h37, 8'h30);
        wait_idle();
        show_alarm = 1'b0;

        // Reset during digit 2 aborts the frame without frame_done.
        current_time = 16'h1234;
        start_frame(8'h34, 8'h33, 8'h32, 8'h31);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        done_exp = 1'b0;
        chk("abort_valid", lcd_valid, 1'b0);
        chk("abort_done", frame_done, 1'b0);
        @(posedge clock);
        #1;
        start_frame(8'h34, 8'h33, 8'h32, 8'h31);
        wait_idle();
        current_time = 16'h0000;
        repeat (3) @(posedge clock);
        #1;

        // Alarm timeout: exactly 16 cycles, no re-trigger while the match holds.
        current_time = 16'h0700;
        @(posedge clock);
        #1;
        chk("alarm_pre", sound_alarm, 1'b0);
        @(posedge clock);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("alarm_on", sound_alarm, 1'b1);
            @(posedge clock);
        end
        #1;
        chk("alarm_timeout", sound_alarm, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("alarm_no_retrig", sound_alarm, 1'b0);
        end
        current_time = 16'h0000;
        repeat (3) @(posedge clock);
        #1;

        // Ack on the third sounding cycle.
        current_time = 16'h0700;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("ack_on1", sound_alarm, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("ack_on3", sound_alarm, 1'b1);
        alarm_ack = 1'b1;
        @(posedge clock);
        #1;
        alarm_ack = 1'b0;
        chk("ack_off", sound_alarm, 1'b0);
        @(posedge clock);
        #1;
        chk("ack_stay_off", sound_alarm, 1'b0);
        current_time = 16'h0000;
        repeat (3) @(posedge clock);
        #1;

        // Ack coincident with the rising match suppresses the alarm entirely.
        current_time = 16'h0700;
        @(posedge clock);
        #1;
        alarm_ack = 1'b1;
        @(posedge clock);
        #1;
        alarm_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ack_coincident", sound_alarm, 1'b0);
            @(posedge clock);
            #1;
        end
        current_time = 16'h0000;
        repeat (2) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_scan_driver.md
LCD_SCAN_DRIVER -- requirements
Module: lcd_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: BCD digits per time value (2..8).
REQ-002 SHALL have parameter ALARM_CYCLES, default 16: maximum sound_alarm duration in clocks (1..65535).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 key_time  in  4*NUM_DIGITS  keypad-entered time, BCD, digit 0 in bits [3:0].
REQ-007 alarm_time  in  4*NUM_DIGITS  stored alarm time, BCD.
REQ-008 current_time  in  4*NUM_DIGITS  running time, BCD.
REQ-009 show_new_time  in  1  selects key_time; has priority over show_alarm.
REQ-010 show_alarm  in  1  selects alarm_time when show_new_time is low; current_time otherwise.
REQ-011 refresh  in  1  single-cycle request to send one frame.
REQ-012 lcd_ready  in  1  LCD accepts a character this cycle.
REQ-013 alarm_ack  in  1  user silences the alarm.
REQ-014 lcd_data  out  8  ASCII character for the digit being sent.
REQ-015 lcd_digit_sel  out  max(1,clog2(NUM_DIGITS))  index of the digit being sent.
REQ-016 lcd_valid  out  1  lcd_data/lcd_digit_sel valid.
REQ-017 frame_done  out  1  one-cycle pulse after the last digit is accepted.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 sound_alarm  out  1  alarm sounder enable.

Function
REQ-020 Frame FSM SHALL use states IDLE, SEND and DONE.
- IDLE: on refresh, register the selected source (priority per REQ-009/010) into a frame snapshot, set digit index to 0, go to SEND.
- SEND: lcd_valid high; when lcd_ready is high, advance the index; on acceptance of digit NUM_DIGITS-1, go to DONE.
- DONE: frame_done high for 1 cycle, then IDLE.
REQ-021 Digits SHALL be sent from the snapshot, so input changes mid-frame do not alter the frame.
REQ-022 refresh while busy SHALL be ignored and not queued.
REQ-023 lcd_data SHALL be 8'h30+d for snapshot digit d in 0..9, and 8'h3A (ERROR) for d in 10..15.
REQ-024 While lcd_valid is high and lcd_ready is low, lcd_data and lcd_digit_sel SHALL hold stable.
REQ-025 Minimum frame latency SHALL be refresh -> first lcd_valid 1 cycle, NUM_DIGITS cycles in SEND, then frame_done on the next cycle.
REQ-026 Alarm match SHALL be true when all NUM_DIGITS digits of current_time equal alarm_time; the match is registered each cycle.
REQ-027 sound_alarm SHALL assert the cycle after a rising edge of the registered match, and not merely on a held match.
REQ-028 sound_alarm SHALL deassert on the first of: alarm_ack high, or ALARM_CYCLES cycles elapsed.
REQ-029 While the match persists after ack or timeout, the alarm SHALL NOT re-trigger.
REQ-030 alarm_ack in the same cycle as a rising match SHALL win: sound_alarm stays low.
REQ-031 A new rising match while sounding SHALL restart the duration counter.
REQ-032 The alarm logic SHALL be independent of the frame FSM and of the show_* inputs.

Reset
REQ-033 Reset SHALL force state IDLE, and drive lcd_valid=0, frame_done=0, busy=0, sound_alarm=0, lcd_digit_sel=0, lcd_data=8'h30.
REQ-034 Reset SHALL clear the snapshot, the registered match and the duration counter.
REQ-035 Reset mid-frame SHALL abort the frame with no frame_done pulse.
REQ-036 A match present at reset release SHALL count as a rising match one cycle later.

Structure
REQ-037 The shared package lcd_pkg SHALL hold:
- the ASCII constants ZERO..NINE and ERROR;
- the frame state enum.
REQ-038 The BCD-to-ASCII converter SHALL be a sub-module bcd_to_ascii (combinational, 4-bit in, 8-bit out).
REQ-039 The alarm detector SHALL remain inline.

Verification
REQ-040 Verification SHALL cover the scenarios below (NUM_DIGITS=4):
- Frame: current_time=16'h1234, refresh, lcd_ready=1 -> 31,32,33,34 with sel 3,2,1,0 reversed order not allowed; sel 0..3 carries 34,33,32,31 from digit 0 upward; frame_done at cycle 6.
- Backpressure and priority: show_new_time=show_alarm=1, key_time=16'h0009, lcd_ready low 3 cycles on digit 0 -> lcd_data 8'h39 held stable 4 cycles.
- Invalid digit: key_time digit value 4'hB -> lcd_data 8'h3A for that digit.
- Alarm timeout: match from cycle 10, ALARM_CYCLES=16 -> sound_alarm high for exactly 16 cycles, no re-trigger while the match holds.
- Alarm ack: alarm_ack on cycle 3 of sounding -> sound_alarm low next cycle; alarm_ack coincident with rising match -> no assertion.
- Reset mid-frame: reset during digit 2 -> lcd_valid low next cycle, no frame_done; a following refresh yields a full frame.
